mode_select_fsm: RTL and testbench

//  Parametrised top-level mode sequencer; successor to the fixed two-game menu FSM.

---
 rtl/mode_select_fsm.sv | 141 ++++++++++++++
 tb/tb_mode_select_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_select_fsm.sv
// Top-level game mode sequencer: picks one of NUM_MODES games from held select keys,
// debounces key release and the back key, and emits one-cycle enter/exit strobes.
module mode_select_fsm #(
  parameter  int NUM_MODES  = 2,
  parameter  int DEB_CYCLES = 16,
  localparam int MODE_W     = $clog2(NUM_MODES + 1)
) (
  input  logic                 clk,
  input  logic                 iReset,
  input  logic [NUM_MODES-1:0] iSelect,
  input  logic                 iBack,
  output logic [MODE_W-1:0]    oMode,
  output logic                 oEnter,
  output logic                 oExit,
  output logic                 oBusy
);

  localparam int CNT_W  = $clog2(DEB_CYCLES + 1);
  localparam int PEND_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    MENU      = 2'd0,
    SEL_WAIT  = 2'd1,
    ACTIVE    = 2'd2,
    EXIT_WAIT = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic                  armed, armed_nx;
  logic [PEND_W-1:0]     pend, pend_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [MODE_W-1:0]     mode_nx;
  logic                  enter_nx, exit_nx, busy_nx;
  logic [NUM_MODES-1:0]  pend_mask;
  logic                  sel_held;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1'b1;
  endfunction

  // Lowest set bit wins when several select keys are held together.
  function automatic logic [PEND_W-1:0] lowest_idx(input logic [NUM_MODES-1:0] v);
    logic [PEND_W-1:0] idx;
    idx = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (v[i]) idx = PEND_W'(i);
    end
    return idx;
  endfunction

  assign pend_mask = NUM_MODES'(1) << pend;
  assign sel_held  = |(iSelect & pend_mask);

  always_ff @(posedge clk) begin
    if (iReset) begin
      state  <= MENU;
      armed  <= 1'b0;
      pend   <= '0;
      cnt    <= '0;
      oMode  <= '0;
      oEnter <= 1'b0;
      oExit  <= 1'b0;
      oBusy  <= 1'b0;
    end else begin
      state  <= state_nx;
      armed  <= armed_nx;
      pend   <= pend_nx;
      cnt    <= cnt_nx;
      oMode  <= mode_nx;
      oEnter <= enter_nx;
      oExit  <= exit_nx;
      oBusy  <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    armed_nx = armed;
    pend_nx  = pend;
    cnt_nx   = cnt;
    mode_nx  = oMode;
    enter_nx = 1'b0;
    exit_nx  = 1'b0;
    case (state)
      MENU: begin
        mode_nx = '0;
        // A key still held from before the menu was entered must be released first.
        if (iSelect == '0) begin
          armed_nx = 1'b1;
        end else if (armed) begin
          pend_nx  = lowest_idx(iSelect);
          cnt_nx   = '0;
          state_nx = SEL_WAIT;
        end
      end
      SEL_WAIT: begin
        if (iBack) begin
          cnt_nx   = '0;
          state_nx = EXIT_WAIT;
        end else if (sel_held) begin
          cnt_nx = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nx = ACTIVE;
          mode_nx  = MODE_W'(pend) + MODE_W'(1);
          enter_nx = 1'b1;
        end else begin
          cnt_nx = sat_inc(cnt);
        end
      end
      ACTIVE: begin
        if (iBack) begin
          cnt_nx   = '0;
          state_nx = EXIT_WAIT;
        end
      end
      EXIT_WAIT: begin
        if (iBack) begin
          cnt_nx = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nx = MENU;
          mode_nx  = '0;
          exit_nx  = 1'b1;
          armed_nx = 1'b0;
        end else begin
          cnt_nx = sat_inc(cnt);
        end
      end
      default: begin
        state_nx = MENU;
        armed_nx = 1'b0;
        pend_nx  = '0;
        cnt_nx   = '0;
        mode_nx  = '0;
      end
    endcase
    busy_nx = (state_nx == SEL_WAIT) || (state_nx == EXIT_WAIT);
  end

endmodule

// File: tb/tb_mode_select_fsm.sv
// Scenario bench for mode_select_fsm: NUM_MODES=3/DEB_CYCLES=4 main instance plus a
// NUM_MODES=1/DEB_CYCLES=1 smoke instance; expected outputs queued per driven cycle.
module tb_mode_select_fsm;

  logic       clk = 1'b0;
  logic       iReset;
  logic [2:0] iSelect;
  logic       iBack;
  logic [1:0] oMode;
  logic       oEnter, oExit, oBusy;

  logic       s_rst, s_sel, s_back;
  logic [0:0] s_mode;
  logic       s_enter, s_exit, s_busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       rst;
    logic [2:0] sel;
    logic       back;
    logic [1:0] mode;
    logic       en;
    logic       ex;
    logic       busy;
  } step_t;

  logic [4:0] sb [$];
  logic [3:0] sb1 [$];

  always #5 clk = ~clk;

  mode_select_fsm #(.NUM_MODES(3), .DEB_CYCLES(4)) dut (
    .clk(clk), .iReset(iReset), .iSelect(iSelect), .iBack(iBack),
    .oMode(oMode), .oEnter(oEnter), .oExit(oExit), .oBusy(oBusy)
  );

  mode_select_fsm #(.NUM_MODES(1), .DEB_CYCLES(1)) dut1 (
    .clk(clk), .iReset(s_rst), .iSelect(s_sel), .iBack(s_back),
    .oMode(s_mode), .oEnter(s_enter), .oExit(s_exit), .oBusy(s_busy)
  );

  function automatic step_t st(input logic r, input logic [2:0] sel, input logic b,
                               input logic [1:0] m, input logic en, input logic ex,
                               input logic busy);
    return '{rst: r, sel: sel, back: b, mode: m, en: en, ex: ex, busy: busy};
  endfunction

  task automatic cyc(input step_t s);
    iReset  = s.rst;
    iSelect = s.sel;
    iBack   = s.back;
    sb.push_back({s.mode, s.en, s.ex, s.busy});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input step_t s);
    s_rst  = s.rst;
    s_sel  = s.sel[0];
    s_back = s.back;
    sb1.push_back({s.mode[0], s.en, s.ex, s.busy});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t t[$];
    logic [4:0] got, exp;
    t = '{st(1,0,0, 0,0,0,0), st(1,0,0, 0,0,0,0)};
    foreach (t[i]) begin
      cyc(t[i]);
      got = {oMode, oEnter, oExit, oBusy};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d] mode/en/ex/busy got=%b required=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_select();
    step_t t[$];
    logic [4:0] got, exp;
    t = '{st(0,0,0, 0,0,0,0),
          st(0,2,0, 0,0,0,1), st(0,2,0, 0,0,0,1), st(0,2,0, 0,0,0,1),
          st(0,2,0, 0,0,0,1), st(0,2,0, 0,0,0,1),
          st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1),
          st(0,0,0, 2,1,0,0), st(0,0,0, 2,0,0,0)};
    foreach (t[i]) begin
      cyc(t[i]);
      got = {oMode, oEnter, oExit, oBusy};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL select[%0d] mode/en/ex/busy got=%b required=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_back();
    step_t t[$];
    logic [4:0] got, exp;
    t = '{st(0,0,1, 2,0,0,1), st(0,0,1, 2,0,0,1), st(0,0,1, 2,0,0,1),
          st(0,0,0, 2,0,0,1), st(0,0,0, 2,0,0,1), st(0,0,0, 2,0,0,1),
          st(0,0,0, 0,0,1,0), st(0,0,0, 0,0,0,0)};
    foreach (t[i]) begin
      cyc(t[i]);
      got = {oMode, oEnter, oExit, oBusy};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL back[%0d] mode/en/ex/busy got=%b required=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_multi_bounce();
    step_t t[$];
    logic [4:0] got, exp;
    t = '{st(0,6,0, 0,0,0,1),
          st(0,4,0, 0,0,0,1), st(0,0,0, 0,0,0,1), st(0,2,0, 0,0,0,1),
          st(0,4,0, 0,0,0,1), st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1),
          st(0,0,0, 2,1,0,0),
          st(0,0,1, 2,0,0,1),
          st(0,0,0, 2,0,0,1), st(0,0,0, 2,0,0,1), st(0,0,0, 2,0,0,1),
          st(0,0,0, 0,0,1,0), st(0,0,0, 0,0,0,0)};
    foreach (t[i]) begin
      cyc(t[i]);
      got = {oMode, oEnter, oExit, oBusy};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL multi_bounce[%0d] mode/en/ex/busy got=%b required=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_rearm();
    step_t t[$];
    logic [4:0] got, exp;
    t = '{st(0,4,0, 0,0,0,1),
          st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1),
          st(0,0,0, 3,1,0,0),
          st(0,1,1, 3,0,0,1),
          st(0,1,0, 3,0,0,1), st(0,1,0, 3,0,0,1), st(0,1,0, 3,0,0,1),
          st(0,1,0, 0,0,1,0),
          st(0,1,0, 0,0,0,0), st(0,1,0, 0,0,0,0), st(0,1,0, 0,0,0,0),
          st(0,0,0, 0,0,0,0),
          st(0,1,0, 0,0,0,1),
          st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1),
          st(0,0,0, 1,1,0,0)};
    foreach (t[i]) begin
      cyc(t[i]);
      got = {oMode, oEnter, oExit, oBusy};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rearm[%0d] mode/en/ex/busy got=%b required=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_abort();
    step_t t[$];
    logic [4:0] got, exp;
    t = '{st(0,0,1, 1,0,0,1),
          st(0,0,0, 1,0,0,1), st(0,0,0, 1,0,0,1), st(0,0,0, 1,0,0,1),
          st(0,0,0, 0,0,1,0), st(0,0,0, 0,0,0,0),
          st(0,2,0, 0,0,0,1),
          st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1),
          st(0,0,1, 0,0,0,1),
          st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1),
          st(0,0,0, 0,0,1,0), st(0,0,0, 0,0,0,0)};
    foreach (t[i]) begin
      cyc(t[i]);
      got = {oMode, oEnter, oExit, oBusy};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL abort[%0d] mode/en/ex/busy got=%b required=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_active();
    step_t t[$];
    logic [4:0] got, exp;
    t = '{st(0,4,0, 0,0,0,1),
          st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1), st(0,0,0, 0,0,0,1),
          st(0,0,0, 3,1,0,0), st(0,0,0, 3,0,0,0),
          st(1,4,1, 0,0,0,0),
          st(0,4,1, 0,0,0,0), st(0,0,0, 0,0,0,0), st(0,0,1, 0,0,0,0),
          st(0,0,0, 0,0,0,0)};
    foreach (t[i]) begin
      cyc(t[i]);
      got = {oMode, oEnter, oExit, oBusy};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_active[%0d] mode/en/ex/busy got=%b required=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_smoke_single();
    step_t t[$];
    logic [3:0] got, exp;
    t = '{st(1,0,0, 0,0,0,0), st(0,0,0, 0,0,0,0), st(0,1,0, 0,0,0,1),
          st(0,0,0, 1,1,0,0), st(0,0,0, 1,0,0,0), st(0,0,1, 1,0,0,1),
          st(0,0,0, 0,0,1,0), st(0,0,0, 0,0,0,0)};
    foreach (t[i]) begin
      cyc1(t[i]);
      got = {s_mode, s_enter, s_exit, s_busy};
      exp = sb1.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL smoke_single[%0d] mode/en/ex/busy got=%b required=%b", i, got, exp);
      end
    end
  endtask

  initial begin
    iReset  = 1'b1;
    iSelect = '0;
    iBack   = 1'b0;
    s_rst   = 1'b1;
    s_sel   = 1'b0;
    s_back  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_select();
    test_back();
    test_multi_bounce();
    test_rearm();
    test_abort();
    test_reset_active();
    test_smoke_single();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
